// File: rtl/vram_slot_arbiter_if.sv
// rtl/vram_slot_arbiter_if.sv - signal bundle between timing/fetch/CPU side and the VRAM slot arbiter
interface vram_slot_arbiter_if #(
   parameter int AW = 12,
   parameter int DW = 8
);
   logic [8:0]    HPOS;
   logic          HBLK;
   logic          VBLK;
   logic [AW-1:0] VID_ADR;
   logic [DW-1:0] VID_DO;
   logic          VID_VALID;
   logic          CPU_REQ;
   logic          CPU_WE;
   logic [AW-1:0] CPU_ADR;
   logic [DW-1:0] CPU_DI;
   logic [DW-1:0] CPU_DO;
   logic          CPU_ACK;
   logic          CPU_WAIT;
   logic [AW-1:0] MEM_ADR;
   logic          MEM_WE;
   logic [DW-1:0] MEM_DI;
   logic [DW-1:0] MEM_DO;

   modport slave (
      input  HPOS, HBLK, VBLK, VID_ADR, CPU_REQ, CPU_WE, CPU_ADR, CPU_DI, MEM_DO,
      output VID_DO, VID_VALID, CPU_DO, CPU_ACK, CPU_WAIT, MEM_ADR, MEM_WE, MEM_DI
   );

   modport master (
      output HPOS, HBLK, VBLK, VID_ADR, CPU_REQ, CPU_WE, CPU_ADR, CPU_DI, MEM_DO,
      input  VID_DO, VID_VALID, CPU_DO, CPU_ACK, CPU_WAIT, MEM_ADR, MEM_WE, MEM_DI
   );
endinterface

// File: rtl/vram_slot_arbiter.sv
// rtl/vram_slot_arbiter.sv - time-slot arbiter sharing one sync-read VRAM between tile fetch and CPU
module vram_slot_arbiter #(
   parameter int AW       = 12,
   parameter int DW       = 8,
   parameter int CPU_SLOT = 3
) (
   input  logic               CLK,
   input  logic               RST_N,
   vram_slot_arbiter_if.slave bus
);
   localparam logic [1:0] CPU_PHASE = CPU_SLOT[1:0];

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_ISSUE, S_WAITD} state_t;

   state_t        state_q, state_d;
   logic          vid_slot, free_slot;
   logic          accept, issue;
   logic [AW-1:0] pend_adr;
   logic          pend_we;
   logic [DW-1:0] pend_di;
   logic [AW-1:0] mem_adr_q;
   logic          mem_we_q;
   logic [DW-1:0] mem_di_q;
   logic [1:0]    vtag;
   logic [DW-1:0] vid_do_q;
   logic          vid_valid_q;
   logic [DW-1:0] cpu_do_q;
   logic          cpu_ack_q;
   logic          unused_hpos;

   // Only the low two HPOS bits select the slot phase; the rest is don't-care.
   assign unused_hpos = ^bus.HPOS[8:2];

   // Video owns 3 of 4 pixel clocks during active display; everything else is CPU time.
   assign vid_slot  = ~bus.HBLK & ~bus.VBLK & (bus.HPOS[1:0] != CPU_PHASE);
   assign free_slot = ~vid_slot;

   assign bus.MEM_ADR   = mem_adr_q;
   assign bus.MEM_WE    = mem_we_q;
   assign bus.MEM_DI    = mem_di_q;
   assign bus.VID_DO    = vid_do_q;
   assign bus.VID_VALID = vid_valid_q;
   assign bus.CPU_DO    = cpu_do_q;
   assign bus.CPU_ACK   = cpu_ack_q;
   assign bus.CPU_WAIT  = bus.CPU_REQ & ~cpu_ack_q;

   // CPU access state register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // CPU access sequencing; a request still high in the ack cycle is ignored.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      issue   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.CPU_REQ && !cpu_ack_q) begin
               accept  = 1'b1;
               state_d = S_PEND;
            end
         end
         S_PEND: begin
            if (free_slot) begin
               issue   = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAITD;
         S_WAITD: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Capture the CPU request so the CPU bus may change while we wait for a slot.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pend_adr <= '0;
         pend_we  <= 1'b0;
         pend_di  <= '0;
      end else if (accept) begin
         pend_adr <= bus.CPU_ADR;
         pend_we  <= bus.CPU_WE;
         pend_di  <= bus.CPU_DI;
      end
   end

   // RAM port: video slot first, CPU only in a free slot; write strobe lasts one clock.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mem_adr_q <= '0;
         mem_we_q  <= 1'b0;
         mem_di_q  <= '0;
      end else if (vid_slot) begin
         mem_adr_q <= bus.VID_ADR;
         mem_we_q  <= 1'b0;
      end else if (issue) begin
         mem_adr_q <= pend_adr;
         mem_we_q  <= pend_we;
         mem_di_q  <= pend_di;
      end else begin
         mem_we_q  <= 1'b0;
      end
   end

   // Video return pipeline: tag follows the read through the RAM's one-clock latency.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         vtag        <= 2'b00;
         vid_valid_q <= 1'b0;
         vid_do_q    <= '0;
      end else begin
         vtag        <= {vtag[0], vid_slot};
         vid_valid_q <= vtag[1];
         if (vtag[1]) vid_do_q <= bus.MEM_DO;
      end
   end

   // CPU completion: return read data and pulse ACK once; writes leave CPU_DO untouched.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cpu_ack_q <= 1'b0;
         cpu_do_q  <= '0;
      end else begin
         cpu_ack_q <= (state_q == S_WAITD);
         if (state_q == S_WAITD && !pend_we) cpu_do_q <= bus.MEM_DO;
      end
   end
endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb/tb_vram_slot_arbiter.sv - directed self-checking bench for vram_slot_arbiter
module tb_vram_slot_arbiter;
   logic CLK = 1'b0;
   logic RST_N;
   int   chk_cnt = 0;
   int   pass_cnt = 0;
   int   ack_cnt = 0;
   int   we_cnt = 0;
   logic ram_ready = 1'b0;
   logic [7:0] mem [0:4095];

   vram_slot_arbiter_if #(.AW(12), .DW(8)) bus ();

   vram_slot_arbiter #(.AW(12), .DW(8), .CPU_SLOT(3)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   assign bus.VID_ADR = {3'b000, bus.HPOS};

   // Synchronous-read RAM, preloaded with addr LSBs and 0x5A at 0x123.
   always @(posedge CLK) begin
      if (!ram_ready) begin
         for (int i = 0; i < 4096; i++) mem[i] <= i[7:0];
         mem[12'h123] <= 8'h5A;
         ram_ready <= 1'b1;
      end else begin
         if (bus.MEM_WE) mem[bus.MEM_ADR] <= bus.MEM_DI;
         bus.MEM_DO <= mem[bus.MEM_ADR];
      end
   end

   always @(negedge CLK) begin
      if (bus.CPU_ACK) ack_cnt <= ack_cnt + 1;
      if (bus.MEM_WE)  we_cnt  <= we_cnt + 1;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ack(input int max_cyc, output bit got);
      got = 1'b0;
      for (int i = 0; i < max_cyc && !got; i++) begin
         tick();
         if (bus.CPU_ACK) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      bus.HPOS = 9'd0; bus.HBLK = 1'b1; bus.VBLK = 1'b1;
      bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0; bus.CPU_ADR = '0; bus.CPU_DI = '0;
      repeat (3) tick();
      chk_cnt++; if (bus.VID_VALID !== 1'b0) $display("FAIL rst_vid_valid got %0b want 0", bus.VID_VALID); else pass_cnt++;
      chk_cnt++; if (bus.CPU_ACK !== 1'b0) $display("FAIL rst_cpu_ack got %0b want 0", bus.CPU_ACK); else pass_cnt++;
      chk_cnt++; if (bus.MEM_WE !== 1'b0) $display("FAIL rst_mem_we got %0b want 0", bus.MEM_WE); else pass_cnt++;
      chk_cnt++; if (bus.MEM_ADR !== 12'h000) $display("FAIL rst_mem_adr got %h want 000", bus.MEM_ADR); else pass_cnt++;
      chk_cnt++; if (bus.CPU_DO !== 8'h00) $display("FAIL rst_cpu_do got %h want 00", bus.CPU_DO); else pass_cnt++;
      chk_cnt++; if (bus.VID_DO !== 8'h00) $display("FAIL rst_vid_do got %h want 00", bus.VID_DO); else pass_cnt++;
      chk_cnt++; if (bus.CPU_WAIT !== 1'b0) $display("FAIL rst_cpu_wait got %0b want 0", bus.CPU_WAIT); else pass_cnt++;
      RST_N = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_video();
      for (int j = 0; j < 16; j++) begin
         int s;
         bit exp_v;
         s = j - 3;
         exp_v = (s >= 0) && (s < 12) && ((s % 4) != 3);
         chk_cnt++; if (bus.VID_VALID !== exp_v) $display("FAIL vid_valid_%0d got %0b want %0b", j, bus.VID_VALID, exp_v); else pass_cnt++;
         if (exp_v) begin
            chk_cnt++; if (bus.VID_DO !== s[7:0]) $display("FAIL vid_do_%0d got %h want %h", j, bus.VID_DO, s[7:0]); else pass_cnt++;
         end
         if (j < 12) begin
            bus.HPOS = j[8:0]; bus.HBLK = 1'b0; bus.VBLK = 1'b0;
         end else begin
            bus.HBLK = 1'b1;
         end
         tick();
      end
   endtask

   task automatic test_cpu_read_active();
      bus.HPOS = 9'd4; bus.HBLK = 1'b0; bus.VBLK = 1'b0;
      bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_ADR = 12'h123; bus.CPU_DI = 8'h00;
      #1;
      chk_cnt++; if (bus.CPU_WAIT !== 1'b1) $display("FAIL rd_wait_on_req got %0b want 1", bus.CPU_WAIT); else pass_cnt++;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 3) begin
            chk_cnt++; if (bus.MEM_ADR !== 12'h006) $display("FAIL rd_video_holds_bus got %h want 006", bus.MEM_ADR); else pass_cnt++;
         end
         if (k == 4) begin
            chk_cnt++; if (bus.MEM_ADR !== 12'h123) $display("FAIL rd_issue_adr got %h want 123", bus.MEM_ADR); else pass_cnt++;
            chk_cnt++; if (bus.MEM_WE !== 1'b0) $display("FAIL rd_issue_we got %0b want 0", bus.MEM_WE); else pass_cnt++;
         end
         if (k == 5) begin
            chk_cnt++; if (bus.CPU_WAIT !== 1'b1 || bus.CPU_ACK !== 1'b0) $display("FAIL rd_wait_before_ack got wait=%0b ack=%0b want wait=1 ack=0", bus.CPU_WAIT, bus.CPU_ACK); else pass_cnt++;
         end
         if (k == 6) begin
            chk_cnt++; if (bus.CPU_ACK !== 1'b1) $display("FAIL rd_ack got %0b want 1", bus.CPU_ACK); else pass_cnt++;
            chk_cnt++; if (bus.CPU_DO !== 8'h5A) $display("FAIL rd_data got %h want 5a", bus.CPU_DO); else pass_cnt++;
            chk_cnt++; if (bus.CPU_WAIT !== 1'b0) $display("FAIL rd_wait_at_ack got %0b want 0", bus.CPU_WAIT); else pass_cnt++;
            bus.CPU_REQ = 1'b0;
         end
         bus.HPOS = 9'd4 + k[8:0];
      end
      tick();
      chk_cnt++; if (bus.CPU_ACK !== 1'b0) $display("FAIL rd_ack_one_cycle got %0b want 0", bus.CPU_ACK); else pass_cnt++;
      bus.HBLK = 1'b1; bus.VBLK = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_cpu_write_blank();
      bit got;
      bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADR = 12'h0A0; bus.CPU_DI = 8'hC3;
      tick();
      chk_cnt++; if (bus.MEM_WE !== 1'b0) $display("FAIL wr_we_before_issue got %0b want 0", bus.MEM_WE); else pass_cnt++;
      tick();
      chk_cnt++; if (bus.MEM_WE !== 1'b1 || bus.MEM_ADR !== 12'h0A0 || bus.MEM_DI !== 8'hC3) $display("FAIL wr_issue got we=%0b adr=%h di=%h want we=1 adr=0a0 di=c3", bus.MEM_WE, bus.MEM_ADR, bus.MEM_DI); else pass_cnt++;
      tick();
      chk_cnt++; if (bus.MEM_WE !== 1'b0 || bus.CPU_ACK !== 1'b0) $display("FAIL wr_we_one_clock got we=%0b ack=%0b want 0 0", bus.MEM_WE, bus.CPU_ACK); else pass_cnt++;
      tick();
      chk_cnt++; if (bus.CPU_ACK !== 1'b1) $display("FAIL wr_ack got %0b want 1", bus.CPU_ACK); else pass_cnt++;
      chk_cnt++; if (bus.CPU_DO !== 8'h5A) $display("FAIL wr_cpu_do_held got %h want 5a", bus.CPU_DO); else pass_cnt++;
      bus.CPU_REQ = 1'b0;
      tick();
      chk_cnt++; if (we_cnt !== 1) $display("FAIL wr_we_count got %0d want 1", we_cnt); else pass_cnt++;
      bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_ADR = 12'h0A0;
      wait_ack(10, got);
      chk_cnt++; if (got !== 1'b1) $display("FAIL wr_readback_ack got %0b want 1", got); else pass_cnt++;
      chk_cnt++; if (bus.CPU_DO !== 8'hC3) $display("FAIL wr_readback_data got %h want c3", bus.CPU_DO); else pass_cnt++;
      bus.CPU_REQ = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_back_to_back();
      bit got;
      int a0;
      a0 = ack_cnt;
      bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_ADR = 12'h005;
      wait_ack(10, got);
      chk_cnt++; if (got !== 1'b1) $display("FAIL b2b_first_ack got %0b want 1", got); else pass_cnt++;
      chk_cnt++; if (bus.CPU_DO !== 8'h05) $display("FAIL b2b_first_data got %h want 05", bus.CPU_DO); else pass_cnt++;
      tick();
      chk_cnt++; if (bus.CPU_ACK !== 1'b0) $display("FAIL b2b_no_reaccept_ack got %0b want 0", bus.CPU_ACK); else pass_cnt++;
      bus.CPU_REQ = 1'b0;
      tick();
      chk_cnt++; if (ack_cnt - a0 !== 1) $display("FAIL b2b_single_ack got %0d want 1", ack_cnt - a0); else pass_cnt++;
      bus.CPU_REQ = 1'b1; bus.CPU_ADR = 12'h007;
      wait_ack(10, got);
      chk_cnt++; if (got !== 1'b1) $display("FAIL b2b_second_ack got %0b want 1", got); else pass_cnt++;
      chk_cnt++; if (bus.CPU_DO !== 8'h07) $display("FAIL b2b_second_data got %h want 07", bus.CPU_DO); else pass_cnt++;
      bus.CPU_REQ = 1'b0;
      repeat (3) tick();
      chk_cnt++; if (ack_cnt - a0 !== 2) $display("FAIL b2b_total_acks got %0d want 2", ack_cnt - a0); else pass_cnt++;
   endtask

   task automatic test_blank_to_active();
      bus.HPOS = 9'd511; bus.HBLK = 1'b1; bus.VBLK = 1'b0;
      bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_ADR = 12'h033;
      for (int k = 1; k <= 8; k++) begin
         tick();
         case (k)
            3: begin
               chk_cnt++; if (bus.VID_VALID !== 1'b0) $display("FAIL edge_no_strobe_blank got %0b want 0", bus.VID_VALID); else pass_cnt++;
            end
            4: begin
               chk_cnt++; if (bus.MEM_ADR !== 12'h002 || bus.CPU_WAIT !== 1'b1) $display("FAIL edge_cpu_waits got adr=%h wait=%0b want adr=002 wait=1", bus.MEM_ADR, bus.CPU_WAIT); else pass_cnt++;
               chk_cnt++; if (bus.VID_VALID !== 1'b1 || bus.VID_DO !== 8'h00) $display("FAIL edge_strobe0 got v=%0b d=%h want v=1 d=00", bus.VID_VALID, bus.VID_DO); else pass_cnt++;
            end
            5: begin
               chk_cnt++; if (bus.MEM_ADR !== 12'h033) $display("FAIL edge_issue_adr got %h want 033", bus.MEM_ADR); else pass_cnt++;
               chk_cnt++; if (bus.VID_VALID !== 1'b1 || bus.VID_DO !== 8'h01) $display("FAIL edge_strobe1 got v=%0b d=%h want v=1 d=01", bus.VID_VALID, bus.VID_DO); else pass_cnt++;
            end
            6: begin
               chk_cnt++; if (bus.VID_VALID !== 1'b1 || bus.VID_DO !== 8'h02) $display("FAIL edge_strobe2 got v=%0b d=%h want v=1 d=02", bus.VID_VALID, bus.VID_DO); else pass_cnt++;
            end
            7: begin
               chk_cnt++; if (bus.VID_VALID !== 1'b0) $display("FAIL edge_no_strobe_slot3 got %0b want 0", bus.VID_VALID); else pass_cnt++;
               chk_cnt++; if (bus.CPU_ACK !== 1'b1 || bus.CPU_DO !== 8'h33) $display("FAIL edge_cpu_done got ack=%0b do=%h want ack=1 do=33", bus.CPU_ACK, bus.CPU_DO); else pass_cnt++;
               bus.CPU_REQ = 1'b0;
            end
            default: ;
         endcase
         bus.HPOS = k[8:0] - 9'd1; bus.HBLK = 1'b0;
      end
      bus.HBLK = 1'b1; bus.VBLK = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_reset_mid_write();
      bit got;
      int a0;
      bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADR = 12'h0B0; bus.CPU_DI = 8'h77;
      tick();
      tick();
      chk_cnt++; if (bus.MEM_WE !== 1'b1) $display("FAIL rstmid_in_issue got we=%0b want 1", bus.MEM_WE); else pass_cnt++;
      a0 = ack_cnt;
      RST_N = 1'b0;
      #1;
      chk_cnt++; if (bus.MEM_WE !== 1'b0 || bus.CPU_ACK !== 1'b0 || bus.VID_VALID !== 1'b0) $display("FAIL rstmid_strobes got we=%0b ack=%0b vv=%0b want 0 0 0", bus.MEM_WE, bus.CPU_ACK, bus.VID_VALID); else pass_cnt++;
      chk_cnt++; if (bus.MEM_ADR !== 12'h000) $display("FAIL rstmid_mem_adr got %h want 000", bus.MEM_ADR); else pass_cnt++;
      bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0;
      tick();
      tick();
      RST_N = 1'b1;
      repeat (3) tick();
      chk_cnt++; if (ack_cnt !== a0) $display("FAIL rstmid_no_ack got %0d want %0d", ack_cnt, a0); else pass_cnt++;
      bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b0; bus.CPU_ADR = 12'h0B0;
      wait_ack(10, got);
      chk_cnt++; if (got !== 1'b1) $display("FAIL rstmid_after_ack got %0b want 1", got); else pass_cnt++;
      chk_cnt++; if (bus.CPU_DO !== 8'hB0) $display("FAIL rstmid_write_aborted got %h want b0", bus.CPU_DO); else pass_cnt++;
      bus.CPU_REQ = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_video();
      test_cpu_read_active();
      test_cpu_write_blank();
      test_back_to_back();
      test_blank_to_active();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
